// File: rtl/ram_arbiter_pkg.sv
// Shared types for the two-port RAM arbiter: ownership states and port ids.
package ram_arbiter_pkg;
  localparam int RAM_DEPTH_BITS = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCK_A = 2'd1,
    LOCK_B = 2'd2
  } own_state_e;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_id_e;
endpackage

// File: rtl/ram_arb_pick.sv
// Pure combinational 2-way pick: lock owner first, then fixed or round-robin tie-break.
module ram_arb_pick
  import ram_arbiter_pkg::*;
#(
  parameter int FIXED_PRIO = 0
) (
  input  logic       a_req,
  input  logic       b_req,
  input  port_id_e   rr_last,
  input  own_state_e own_state,
  output logic       a_win,
  output logic       b_win
);
  always_comb begin
    a_win = 1'b0;
    b_win = 1'b0;
    case (own_state)
      LOCK_A: a_win = a_req;
      LOCK_B: b_win = b_req;
      default: begin
        if (a_req && b_req) begin
          // Tie: A wins under fixed priority, else whoever was not served last.
          if (FIXED_PRIO != 0 || rr_last == PORT_B) a_win = 1'b1;
          else                                      b_win = 1'b1;
        end else begin
          a_win = a_req;
          b_win = b_req;
        end
      end
    endcase
  end
endmodule

// File: rtl/ram_arbiter.sv
// Arbitrates one single-beat access per cycle onto a shared single-port RAM,
// with per-requester locking and read data returned one cycle after grant.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int AWIDTH     = 16,
  parameter int FIXED_PRIO = 0
) (
  input  logic              clk,
  input  logic              reset_bar,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [AWIDTH-1:0] a_addr,
  input  logic [WIDTH-1:0]  a_wdata,
  input  logic              a_lock,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [WIDTH-1:0]  a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [AWIDTH-1:0] b_addr,
  input  logic [WIDTH-1:0]  b_wdata,
  input  logic              b_lock,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [WIDTH-1:0]  b_rdata,
  output logic [AWIDTH-1:0] ram_address,
  output logic [WIDTH-1:0]  ram_in,
  output logic              ram_load_bar,
  input  logic [WIDTH-1:0]  ram_value
);
  own_state_e        own_state, own_next;
  port_id_e          rr_last, rd_owner;
  logic              rd_pend;
  logic [AWIDTH-1:0] held_addr;
  logic              a_win, b_win, gnt, win_we, win_lock;

  ram_arb_pick #(.FIXED_PRIO(FIXED_PRIO)) u_pick (
    .a_req     (a_req),
    .b_req     (b_req),
    .rr_last   (rr_last),
    .own_state (own_state),
    .a_win     (a_win),
    .b_win     (b_win)
  );

  // Grants are suppressed while reset is held so the RAM sees no strobe.
  assign a_gnt    = a_win & reset_bar;
  assign b_gnt    = b_win & reset_bar;
  assign gnt      = a_gnt | b_gnt;
  assign win_we   = b_gnt ? b_we   : a_we;
  assign win_lock = b_gnt ? b_lock : a_lock;

  always_comb begin
    ram_address  = held_addr;
    ram_in       = '0;
    ram_load_bar = 1'b1;
    if (gnt) begin
      ram_address  = b_gnt ? b_addr  : a_addr;
      ram_in       = b_gnt ? b_wdata : a_wdata;
      ram_load_bar = ~win_we;
    end
  end

  always_comb begin
    own_next = own_state;
    if (gnt) own_next = win_lock ? (b_gnt ? LOCK_B : LOCK_A) : IDLE;
  end

  always_ff @(posedge clk or negedge reset_bar) begin
    if (!reset_bar) begin
      own_state <= IDLE;
      rr_last   <= PORT_B;
      rd_pend   <= 1'b0;
      rd_owner  <= PORT_A;
      held_addr <= '0;
    end else begin
      own_state <= own_next;
      rd_pend   <= gnt & ~win_we;
      rd_owner  <= b_gnt ? PORT_B : PORT_A;
      if (gnt) begin
        rr_last   <= b_gnt ? PORT_B : PORT_A;
        held_addr <= ram_address;
      end
    end
  end

  // RAM registers its output, so the tag lines up with ram_value one cycle on.
  assign a_rvalid = rd_pend && (rd_owner == PORT_A);
  assign b_rvalid = rd_pend && (rd_owner == PORT_B);
  assign a_rdata  = a_rvalid ? ram_value : '0;
  assign b_rdata  = b_rvalid ? ram_value : '0;
endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: round-robin and fixed-priority instances share stimulus,
// each backed by its own behavioural 256x16 RAM.
module tb_ram_arbiter;
  import ram_arbiter_pkg::*;
  localparam int W  = 16;
  localparam int AW = 16;

  logic clk = 1'b0;
  logic reset_bar = 1'b0;
  logic a_req = 0, a_we = 0, a_lock = 0, b_req = 0, b_we = 0, b_lock = 0;
  logic [AW-1:0] a_addr = '0, b_addr = '0;
  logic [W-1:0]  a_wdata = '0, b_wdata = '0;

  logic          a_gnt [2], b_gnt [2], a_rvalid [2], b_rvalid [2], ram_load_bar [2];
  logic [W-1:0]  a_rdata [2], b_rdata [2], ram_in [2];
  logic [AW-1:0] ram_address [2];

  int n_vec = 0;
  int n_err = 0;

  // reference model state (per instance)
  int            lockh [2], last [2], pend [2];
  logic [AW-1:0] held [2], pend_addr [2];
  logic [W-1:0]  ref_mem [2][256];
  bit            ref_ok [2][256];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : gd
    logic [W-1:0] mem [256];
    logic [W-1:0] value;
    initial for (int i = 0; i < 256; i++) mem[i] = '0;
    always @(posedge clk) begin
      if (!ram_load_bar[g]) mem[ram_address[g][RAM_DEPTH_BITS-1:0]] <= ram_in[g];
      value <= mem[ram_address[g][RAM_DEPTH_BITS-1:0]];
    end
    ram_arbiter #(.WIDTH(W), .AWIDTH(AW), .FIXED_PRIO(g)) u_dut (
      .clk(clk), .reset_bar(reset_bar),
      .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_lock(a_lock),
      .a_gnt(a_gnt[g]), .a_rvalid(a_rvalid[g]), .a_rdata(a_rdata[g]),
      .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_lock(b_lock),
      .b_gnt(b_gnt[g]), .b_rvalid(b_rvalid[g]), .b_rdata(b_rdata[g]),
      .ram_address(ram_address[g]), .ram_in(ram_in[g]), .ram_load_bar(ram_load_bar[g]),
      .ram_value(value)
    );
  end

  task automatic idle_inputs();
    a_req = 0; a_we = 0; a_lock = 0; a_addr = '0; a_wdata = '0;
    b_req = 0; b_we = 0; b_lock = 0; b_addr = '0; b_wdata = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic apply_reset();
    reset_bar = 1'b0;
    idle_inputs();
    next_cycle();
    next_cycle();
    reset_bar = 1'b1;
  endtask

  // lock holder first, then tie-break: lh/lst/result use 0=none, 1=A, 2=B
  function automatic int model_pick(int lh, int lst, bit fp, bit ar, bit br);
    if (lh == 1) return ar ? 1 : 0;
    if (lh == 2) return br ? 2 : 0;
    if (ar && br) return (fp || lst == 2) ? 1 : 2;
    if (ar) return 1;
    if (br) return 2;
    return 0;
  endfunction

  task automatic test_reset();
    reset_bar = 1'b0;
    a_req = 1; a_we = 1; a_addr = 16'h0033; b_req = 1; b_we = 1; b_addr = 16'h0044;
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      n_vec++; if ({a_gnt[g], b_gnt[g], a_rvalid[g], b_rvalid[g], ram_load_bar[g]} !== 5'b00001) begin
        n_err++; $display("FAIL reset_outputs[%0d] got %b want 00001", g, {a_gnt[g], b_gnt[g], a_rvalid[g], b_rvalid[g], ram_load_bar[g]}); end
      n_vec++; if (ram_address[g] !== 16'h0000) begin
        n_err++; $display("FAIL reset_addr[%0d] got %h want 0000", g, ram_address[g]); end
    end
    next_cycle();
    idle_inputs();
    reset_bar = 1'b1;
  endtask

  task automatic test_write_read();
    a_req = 1; a_we = 1; a_addr = 16'h0010; a_wdata = 16'h1234;
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      n_vec++; if ({a_gnt[g], b_gnt[g], ram_load_bar[g]} !== 3'b100) begin
        n_err++; $display("FAIL wr_gnt[%0d] got %b want 100", g, {a_gnt[g], b_gnt[g], ram_load_bar[g]}); end
      n_vec++; if ({ram_address[g], ram_in[g]} !== {16'h0010, 16'h1234}) begin
        n_err++; $display("FAIL wr_pins[%0d] got %h/%h want 0010/1234", g, ram_address[g], ram_in[g]); end
    end
    next_cycle();
    a_we = 0;
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      n_vec++; if ({a_gnt[g], b_gnt[g], ram_load_bar[g], a_rvalid[g]} !== 4'b1010) begin
        n_err++; $display("FAIL rd_gnt[%0d] got %b want 1010", g, {a_gnt[g], b_gnt[g], ram_load_bar[g], a_rvalid[g]}); end
    end
    next_cycle();
    idle_inputs();
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      n_vec++; if ({a_rvalid[g], b_rvalid[g]} !== 2'b10 || a_rdata[g] !== 16'h1234 || b_rdata[g] !== 16'h0) begin
        n_err++; $display("FAIL raw_data[%0d] got rv=%b a=%h b=%h want rv=10 a=1234 b=0000", g, {a_rvalid[g], b_rvalid[g]}, a_rdata[g], b_rdata[g]); end
      n_vec++; if ({ram_address[g], ram_in[g], ram_load_bar[g]} !== {16'h0010, 16'h0, 1'b1}) begin
        n_err++; $display("FAIL idle_pins[%0d] got %h/%h/%b want 0010/0000/1", g, ram_address[g], ram_in[g], ram_load_bar[g]); end
    end
    next_cycle();
  endtask

  task automatic test_back_to_back();
    bit exp_a;
    apply_reset();
    a_req = 1; a_addr = 16'h0010; b_req = 1; b_addr = 16'h0010;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) idle_inputs();
      @(negedge clk);
      exp_a = (i % 2 == 0);
      if (i < 4) begin
        n_vec++; if ({a_gnt[0], b_gnt[0]} !== {exp_a, !exp_a}) begin
          n_err++; $display("FAIL rr_gnt cyc%0d got %b want %b", i, {a_gnt[0], b_gnt[0]}, {exp_a, !exp_a}); end
        n_vec++; if ({a_gnt[1], b_gnt[1]} !== 2'b10) begin
          n_err++; $display("FAIL fixed_gnt cyc%0d got %b want 10", i, {a_gnt[1], b_gnt[1]}); end
      end
      if (i > 0) begin
        n_vec++; if ({a_rvalid[0], b_rvalid[0]} !== {!exp_a, exp_a} || (a_rdata[0] | b_rdata[0]) !== 16'h1234) begin
          n_err++; $display("FAIL rr_rvalid cyc%0d got %b data %h want %b data 1234", i, {a_rvalid[0], b_rvalid[0]}, a_rdata[0] | b_rdata[0], {!exp_a, exp_a}); end
        n_vec++; if ({a_rvalid[1], b_rvalid[1]} !== 2'b10 || a_rdata[1] !== 16'h1234) begin
          n_err++; $display("FAIL fixed_rvalid cyc%0d got %b data %h want 10 data 1234", i, {a_rvalid[1], b_rvalid[1]}, a_rdata[1]); end
      end
      next_cycle();
    end
  endtask

  task automatic test_lock();
    // cycle: 0 locked read, 1 A idle, 2 unlocking write, 3 B served, 4 B data
    logic [1:0] exp_g [4] = '{2'b10, 2'b00, 2'b10, 2'b01};
    apply_reset();
    b_req = 1; b_addr = 16'h0010;
    for (int i = 0; i < 5; i++) begin
      case (i)
        0: begin a_req = 1; a_we = 0; a_addr = 16'h0020; a_lock = 1; end
        1: a_req = 0;
        2: begin a_req = 1; a_we = 1; a_addr = 16'h0021; a_wdata = 16'h5555; a_lock = 0; end
        3: a_req = 0;
        default: idle_inputs();
      endcase
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
        if (i < 4) begin
          n_vec++; if ({a_gnt[g], b_gnt[g]} !== exp_g[i]) begin
            n_err++; $display("FAIL lock_gnt[%0d] cyc%0d got %b want %b", g, i, {a_gnt[g], b_gnt[g]}, exp_g[i]); end
        end
        if (i == 1) begin
          n_vec++; if (a_rvalid[g] !== 1'b1) begin
            n_err++; $display("FAIL lock_rvalid[%0d] got %b want 1", g, a_rvalid[g]); end
        end
        if (i == 4) begin
          n_vec++; if ({b_rvalid[g], b_rdata[g]} !== {1'b1, 16'h1234}) begin
            n_err++; $display("FAIL lock_bdata[%0d] got %b/%h want 1/1234", g, b_rvalid[g], b_rdata[g]); end
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_reset_pending();
    b_req = 1; b_we = 0; b_addr = 16'h0010;
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      n_vec++; if (b_gnt[g] !== 1'b1) begin
        n_err++; $display("FAIL rstp_bgnt[%0d] got %b want 1", g, b_gnt[g]); end
    end
    #1 reset_bar = 1'b0;
    a_req = 1;
    for (int k = 0; k < 2; k++) begin
      if (k == 0) #1; else @(negedge clk);
      for (int g = 0; g < 2; g++) begin
        n_vec++; if ({a_gnt[g], b_gnt[g], a_rvalid[g], b_rvalid[g], ram_load_bar[g]} !== 5'b00001) begin
          n_err++; $display("FAIL rstp_hold[%0d] step%0d got %b want 00001", g, k, {a_gnt[g], b_gnt[g], a_rvalid[g], b_rvalid[g], ram_load_bar[g]}); end
      end
    end
    next_cycle();
    reset_bar = 1'b1;
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      n_vec++; if ({a_gnt[g], b_gnt[g], b_rvalid[g]} !== 3'b100) begin
        n_err++; $display("FAIL rstp_tie[%0d] got %b want 100", g, {a_gnt[g], b_gnt[g], b_rvalid[g]}); end
    end
    next_cycle();
    idle_inputs();
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      n_vec++; if ({a_rvalid[g], b_rvalid[g]} !== 2'b10) begin
        n_err++; $display("FAIL rstp_after[%0d] got %b want 10", g, {a_rvalid[g], b_rvalid[g]}); end
    end
    next_cycle();
  endtask

  task automatic test_alias();
    a_req = 1; a_we = 1; a_addr = 16'h0105; a_wdata = 16'hBEEF;
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      n_vec++; if ({a_gnt[g], ram_address[g]} !== {1'b1, 16'h0105}) begin
        n_err++; $display("FAIL alias_wr[%0d] got %b/%h want 1/0105", g, a_gnt[g], ram_address[g]); end
    end
    next_cycle();
    idle_inputs();
    b_req = 1; b_addr = 16'h0005;
    @(negedge clk);
    next_cycle();
    idle_inputs();
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      n_vec++; if ({b_rvalid[g], b_rdata[g]} !== {1'b1, 16'hBEEF}) begin
        n_err++; $display("FAIL alias_rd[%0d] got %b/%h want 1/beef", g, b_rvalid[g], b_rdata[g]); end
    end
    next_cycle();
  endtask

  task automatic test_random();
    int w [2];
    logic [AW-1:0] ea;
    logic [W-1:0] ei, er;
    logic el;
    w[0] = 0; w[1] = 0;
    apply_reset();
    for (int g = 0; g < 2; g++) begin
      lockh[g] = 0; last[g] = 2; pend[g] = 0; held[g] = '0; pend_addr[g] = '0;
      for (int i = 0; i < 256; i++) ref_ok[g][i] = 1'b0;
    end
    for (int c = 0; c < 400; c++) begin
      // requesters hold their request until served (tracked against instance 0)
      if (!a_req || w[0] == 1) begin
        a_req = ($urandom_range(0, 3) != 0); a_we = 1'($urandom_range(0, 1));
        a_addr = {6'd0, 2'($urandom_range(0, 3)), 4'd0, 4'($urandom_range(0, 15))};
        a_wdata = 16'($urandom); a_lock = ($urandom_range(0, 5) == 0);
      end
      if (!b_req || w[0] == 2) begin
        b_req = ($urandom_range(0, 3) != 0); b_we = 1'($urandom_range(0, 1));
        b_addr = {6'd0, 2'($urandom_range(0, 3)), 4'd0, 4'($urandom_range(0, 15))};
        b_wdata = 16'($urandom); b_lock = ($urandom_range(0, 5) == 0);
      end
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
        w[g] = model_pick(lockh[g], last[g], g == 1, a_req, b_req);
        ea = (w[g] == 1) ? a_addr  : (w[g] == 2) ? b_addr  : held[g];
        ei = (w[g] == 1) ? a_wdata : (w[g] == 2) ? b_wdata : '0;
        el = (w[g] == 1) ? !a_we   : (w[g] == 2) ? !b_we   : 1'b1;
        n_vec++; if ({a_gnt[g], b_gnt[g]} !== {w[g] == 1, w[g] == 2}) begin
          n_err++; $display("FAIL rnd_gnt[%0d] cyc%0d got %b want %b", g, c, {a_gnt[g], b_gnt[g]}, {w[g] == 1, w[g] == 2}); end
        n_vec++; if ({ram_address[g], ram_in[g], ram_load_bar[g]} !== {ea, ei, el}) begin
          n_err++; $display("FAIL rnd_pins[%0d] cyc%0d got %h/%h/%b want %h/%h/%b", g, c, ram_address[g], ram_in[g], ram_load_bar[g], ea, ei, el); end
        n_vec++; if ({a_rvalid[g], b_rvalid[g]} !== {pend[g] == 1, pend[g] == 2}) begin
          n_err++; $display("FAIL rnd_rvalid[%0d] cyc%0d got %b want %b", g, c, {a_rvalid[g], b_rvalid[g]}, {pend[g] == 1, pend[g] == 2}); end
        er = ref_mem[g][pend_addr[g][7:0]];
        if (pend[g] != 1 || ref_ok[g][pend_addr[g][7:0]]) begin
          n_vec++; if (a_rdata[g] !== ((pend[g] == 1) ? er : 16'h0)) begin
            n_err++; $display("FAIL rnd_adata[%0d] cyc%0d got %h want %h", g, c, a_rdata[g], (pend[g] == 1) ? er : 16'h0); end
        end
        if (pend[g] != 2 || ref_ok[g][pend_addr[g][7:0]]) begin
          n_vec++; if (b_rdata[g] !== ((pend[g] == 2) ? er : 16'h0)) begin
            n_err++; $display("FAIL rnd_bdata[%0d] cyc%0d got %h want %h", g, c, b_rdata[g], (pend[g] == 2) ? er : 16'h0); end
        end
        pend[g] = 0;
        if (w[g] != 0) begin
          last[g]  = w[g];
          lockh[g] = ((w[g] == 1) ? a_lock : b_lock) ? w[g] : 0;
          held[g]  = ea;
          if (!el) begin
            ref_mem[g][ea[7:0]] = ei;
            ref_ok[g][ea[7:0]]  = 1'b1;
          end else begin
            pend[g] = w[g];
            pend_addr[g] = ea;
          end
        end
      end
      next_cycle();
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_write_read();
    test_back_to_back();
    test_lock();
    test_reset_pending();
    test_alias();
    test_random();
    next_cycle();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
